// File: rtl/sram_axi_bridge.sv
// SRAM-like instruction/data ports to a single AXI3 master.
// One transaction outstanding; data side has priority over instruction side.
module sram_axi_bridge #(
  parameter int ID_W    = 4,
  parameter int INST_ID = 0,
  parameter int DATA_ID = 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_req,
  input  logic            inst_wr,
  input  logic [1:0]      inst_size,
  input  logic [31:0]     inst_addr,
  input  logic [31:0]     inst_wdata,
  output logic            inst_addr_ok,
  output logic            inst_data_ok,
  output logic [31:0]     inst_rdata,
  input  logic            data_req,
  input  logic            data_wr,
  input  logic [1:0]      data_size,
  input  logic [31:0]     data_addr,
  input  logic [31:0]     data_wdata,
  output logic            data_addr_ok,
  output logic            data_data_ok,
  output logic [31:0]     data_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [3:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] awid,
  output logic [31:0]     awaddr,
  output logic [3:0]      awlen,
  output logic [2:0]      awsize,
  output logic [1:0]      awburst,
  output logic [1:0]      awlock,
  output logic [3:0]      awcache,
  output logic [2:0]      awprot,
  output logic            awvalid,
  input  logic            awready,
  output logic [ID_W-1:0] wid,
  output logic [31:0]     wdata,
  output logic [3:0]      wstrb,
  output logic            wlast,
  output logic            wvalid,
  input  logic            wready,
  input  logic [ID_W-1:0] bid,
  input  logic [1:0]      bresp,
  input  logic            bvalid,
  output logic            bready
);
  typedef enum logic [2:0] {IDLE, RD_AR, RD_R, WR_AW_W, WR_B} state_t;

  localparam logic [ID_W-1:0] IID = ID_W'(INST_ID);
  localparam logic [ID_W-1:0] DID = ID_W'(DATA_ID);

  state_t      state;
  logic        owner_d;   // 1 = data side owns the transaction
  logic        aw_done;
  logic        w_done;
  logic [1:0]  size_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        idle;
  logic        done;

  // Responses carry no information we act on; ids/resp are ignored.
  logic unused_ok;
  assign unused_ok = ^{rid, rresp, rlast, bid, bresp};

  // Outputs are gated by resetn so nothing is asserted while reset is held.
  assign idle = resetn && (state == IDLE);
  assign done = resetn && (((state == RD_R) && rvalid) || ((state == WR_B) && bvalid));

  assign data_addr_ok = idle && data_req;
  assign inst_addr_ok = idle && inst_req && !data_req;
  assign data_data_ok = done && owner_d;
  assign inst_data_ok = done && !owner_d;
  assign inst_rdata   = rdata;
  assign data_rdata   = rdata;

  assign arid    = owner_d ? DID : IID;
  assign awid    = arid;
  assign wid     = arid;
  assign araddr  = addr_q;
  assign awaddr  = addr_q;
  assign arsize  = {1'b0, size_q};
  assign awsize  = {1'b0, size_q};
  assign wdata   = wdata_q;

  assign arvalid = resetn && (state == RD_AR);
  assign rready  = resetn && (state == RD_R);
  assign awvalid = resetn && (state == WR_AW_W) && !aw_done;
  assign wvalid  = resetn && (state == WR_AW_W) && !w_done;
  assign bready  = resetn && (state == WR_B);

  assign arlen   = 4'd0;
  assign awlen   = 4'd0;
  assign arburst = 2'b01;
  assign awburst = 2'b01;
  assign arlock  = 2'b00;
  assign awlock  = 2'b00;
  assign arcache = 4'd0;
  assign awcache = 4'd0;
  assign arprot  = 3'd0;
  assign awprot  = 3'd0;
  assign wlast   = 1'b1;

  // Byte-lane strobe from access size and low address bits; size 3 acts as word.
  always_comb begin
    wstrb = 4'b1111;
    case (size_q)
      2'd0:    wstrb = 4'b0001 << addr_q[1:0];
      2'd1:    wstrb = 4'b0011 << addr_q[1:0];
      default: wstrb = 4'b1111;
    endcase
  end

  // Transaction FSM: accept in IDLE, then run the AXI handshakes to completion.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          aw_done <= 1'b0;
          w_done  <= 1'b0;
          if (data_req) begin
            owner_d <= 1'b1;
            size_q  <= data_size;
            addr_q  <= data_addr;
            wdata_q <= data_wdata;
            state   <= data_wr ? WR_AW_W : RD_AR;
          end else if (inst_req) begin
            owner_d <= 1'b0;
            size_q  <= inst_size;
            addr_q  <= inst_addr;
            wdata_q <= inst_wdata;
            state   <= inst_wr ? WR_AW_W : RD_AR;
          end
        end
        RD_AR: if (arready) state <= RD_R;
        RD_R:  if (rvalid) state <= IDLE;
        WR_AW_W: begin
          if (awready) aw_done <= 1'b1;
          if (wready)  w_done  <= 1'b1;
          if ((aw_done || awready) && (w_done || wready)) state <= WR_B;
        end
        WR_B:  if (bvalid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sram_axi_bridge.sv
// Self-checking bench: acts as CPU and AXI slave, checks against a request-level model.
module tb_sram_axi_bridge;
  localparam int ID_W = 4;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic inst_req = 0, inst_wr = 0, data_req = 0, data_wr = 0;
  logic [1:0] inst_size = 0, data_size = 0;
  logic [31:0] inst_addr = 0, inst_wdata = 0, data_addr = 0, data_wdata = 0;
  logic inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic [ID_W-1:0] arid, awid, wid;
  logic [ID_W-1:0] rid = 0, bid = 0;
  logic [31:0] araddr, awaddr, wdata;
  logic [31:0] rdata = 0;
  logic [3:0] arlen, awlen, arcache, awcache, wstrb;
  logic [2:0] arsize, awsize, arprot, awprot;
  logic [1:0] arburst, awburst, arlock, awlock;
  logic [1:0] rresp = 0, bresp = 0;
  logic arvalid, rready, awvalid, wlast, wvalid, bready;
  logic arready = 0, rlast = 1, rvalid = 0, awready = 0, wready = 0, bvalid = 0;

  int errs = 0;
  int checks = 0;

  sram_axi_bridge #(.ID_W(ID_W), .INST_ID(0), .DATA_ID(1)) dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  // Drive a request on one side (d=1 data, d=0 inst); held until the bridge accepts it.
  task automatic put_req(input bit d, input logic wr, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd);
    if (d) begin
      data_req = 1; data_wr = wr; data_size = sz; data_addr = a; data_wdata = wd;
    end else begin
      inst_req = 1; inst_wr = wr; inst_size = sz; inst_addr = a; inst_wdata = wd;
    end
  endtask

  // Byte-enable mask: the bytes touched by a 1/2/4-byte access starting at addr[1:0].
  function automatic logic [3:0] strb_of(input logic [1:0] sz, input logic [31:0] a);
    int nb;
    logic [3:0] m;
    nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    m = 4'b0000;
    if (nb == 4) m = 4'b1111;
    else for (int b = 0; b < 4; b++) if (b >= int'(a[1:0]) && b < int'(a[1:0]) + nb) m[b] = 1'b1;
    return m;
  endfunction

  // Run one transaction from the IDLE cycle to the edge that completes it.
  // Called just after a rising edge with the bridge in IDLE and requests driven.
  task automatic serve(input int ard, input int rdl, input int awd, input int wdl,
                       input int bdl, input logic [31:0] rv);
    bit d;
    logic wr;
    logic [1:0] sz;
    logic [31:0] a, wd;
    logic [ID_W-1:0] id;
    logic [3:0] strb;
    logic [1:0] own;
    int aw_hs;
    int last;
    d    = data_req;                 // data side always wins
    wr   = d ? data_wr : inst_wr;
    sz   = d ? data_size : inst_size;
    a    = d ? data_addr : inst_addr;
    wd   = d ? data_wdata : inst_wdata;
    id   = d ? ID_W'(1) : ID_W'(0);
    own  = d ? 2'b01 : 2'b10;
    strb = strb_of(sz, a);

    @(negedge clk);
    chk("idle_data_ok", {inst_data_ok, data_data_ok}, 2'b00);
    chk("idle_valids", {arvalid, awvalid, wvalid, rready, bready}, 5'b0);
    chk("accept_addr_ok", {inst_addr_ok, data_addr_ok}, own);
    @(posedge clk); #1;
    // Scramble the accepted side: the bridge must have latched it already.
    if (d) begin data_req = 0; data_addr = $urandom; data_wdata = $urandom; data_wr = ~data_wr; end
    else   begin inst_req = 0; inst_addr = $urandom; inst_wdata = $urandom; inst_wr = ~inst_wr; end

    if (!wr) begin
      for (int c = 0; c <= ard; c++) begin
        arready = (c == ard);
        @(negedge clk);
        chk("arvalid", arvalid, 1);
        chk("araddr", araddr, a);
        chk("arsize", arsize, {1'b0, sz});
        chk("arid", arid, id);
        chk("ar_no_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        @(posedge clk); #1;
      end
      arready = 0;
      for (int c = 0; c <= rdl; c++) begin
        rvalid = (c == rdl);
        rdata  = (c == rdl) ? rv : $urandom;
        @(negedge clk);
        chk("rready", {rready, arvalid}, 2'b10);
        chk("r_data_ok", {inst_data_ok, data_data_ok}, (c == rdl) ? own : 2'b00);
        chk("r_no_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        if (c == rdl) chk("rdata", d ? data_rdata : inst_rdata, rv);
        @(posedge clk); #1;
      end
      rvalid = 0;
    end else begin
      aw_hs = 0;
      last = (awd > wdl) ? awd : wdl;
      for (int c = 0; c <= last; c++) begin
        awready = (c == awd);
        wready  = (c == wdl);
        @(negedge clk);
        chk("awvalid", awvalid, c <= awd);
        chk("wvalid", wvalid, c <= wdl);
        if (c <= awd) begin
          chk("awaddr", awaddr, a);
          chk("awsize", awsize, {1'b0, sz});
          chk("awid", awid, id);
        end
        if (c <= wdl) begin
          chk("wdata", wdata, wd);
          chk("wstrb", wstrb, strb);
          chk("wid_wlast", {wid, wlast}, {id, 1'b1});
        end
        chk("w_no_ok", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok, bready}, 5'b0);
        if (awvalid && awready) aw_hs++;
        @(posedge clk); #1;
      end
      awready = 0; wready = 0;
      chk("aw_count", aw_hs, 1);
      for (int c = 0; c <= bdl; c++) begin
        bvalid = (c == bdl);
        @(negedge clk);
        chk("bready", {bready, awvalid, wvalid}, 3'b100);
        chk("b_data_ok", {inst_data_ok, data_data_ok}, (c == bdl) ? own : 2'b00);
        chk("b_no_addr_ok", {inst_addr_ok, data_addr_ok}, 2'b00);
        @(posedge clk); #1;
      end
      bvalid = 0;
    end
  endtask

  initial begin
    // Reset with both sides requesting: nothing may be accepted or driven.
    inst_req = 1; data_req = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_ok", {inst_addr_ok, data_addr_ok, inst_data_ok, data_data_ok}, 4'b0);
    chk("rst_valids", {arvalid, rready, awvalid, wvalid, bready}, 5'b0);
    chk("rst_regs", {araddr, wdata}, 64'd0);
    chk("rst_awaddr", awaddr, 32'd0);
    chk("tieoffs", {arlen, awlen, arburst, awburst, arlock, awlock, arcache, awcache,
                    arprot, awprot}, {8'd0, 2'b01, 2'b01, 4'd0, 8'd0, 6'd0});
    @(posedge clk); #1;
    inst_req = 0; data_req = 0;
    resetn = 1;
    @(posedge clk); #1;

    // Instruction fetch, rvalid two cycles into RD_R.
    put_req(0, 0, 2'd2, 32'hBFC0_0000, 32'h0);
    serve(0, 2, 0, 0, 0, 32'h3C01_1234);
    // Best-case read.
    put_req(1, 0, 2'd2, 32'h0000_0100, 32'h0);
    serve(0, 0, 0, 0, 0, 32'hCAFE_F00D);
    // Byte store to the top lane; completion waits for bvalid.
    put_req(1, 1, 2'd0, 32'h0000_1003, 32'hAA00_0000);
    serve(0, 0, 0, 0, 2, 32'h0);
    // Simultaneous reads: data first, held inst request taken right after.
    put_req(0, 0, 2'd2, 32'h0000_2000, 32'h0);
    put_req(1, 0, 2'd1, 32'h0000_3002, 32'h0);
    serve(0, 0, 0, 0, 0, 32'h1111_2222);
    serve(0, 0, 0, 0, 0, 32'h3333_4444);
    // Split write handshake: AW immediately, W after 3 cycles.
    put_req(1, 1, 2'd1, 32'h0000_4002, 32'h5566_0000);
    serve(0, 0, 0, 3, 0, 32'h0);
    // AR backpressure for 5 cycles with the instruction side waiting.
    put_req(0, 0, 2'd2, 32'h0000_5000, 32'h0);
    put_req(1, 0, 2'd2, 32'h0000_6000, 32'h0);
    serve(5, 0, 0, 0, 0, 32'h7777_8888);
    serve(0, 1, 0, 0, 0, 32'h9999_AAAA);
    // Instruction-side write is just a write.
    put_req(0, 1, 2'd2, 32'h0000_7004, 32'h1234_5678);
    serve(0, 0, 2, 1, 1, 32'h0);

    // Reset while waiting in RD_R.
    put_req(0, 0, 2'd2, 32'h0000_8000, 32'h0);
    @(posedge clk); #1;
    inst_req = 0; arready = 1;
    @(posedge clk); #1;
    arready = 0;
    @(negedge clk);
    chk("pre_rst_rready", rready, 1);
    @(posedge clk); #1;
    resetn = 0; rvalid = 1;
    @(negedge clk);
    chk("midrst_outs", {arvalid, rready, awvalid, wvalid, bready, inst_data_ok, data_data_ok}, 7'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("midrst_after", {arvalid, rready, inst_data_ok, data_data_ok}, 4'b0);
    @(posedge clk); #1;
    resetn = 1; rvalid = 0;
    put_req(1, 0, 2'd2, 32'h0000_9000, 32'h0);
    serve(0, 0, 0, 0, 0, 32'hDEAD_BEEF);

    // Randomized traffic with random slave delays.
    for (int n = 0; n < 40; n++) begin
      int kind;
      kind = $urandom_range(0, 2);
      if (kind != 1) put_req(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      if (kind != 0) put_req(1, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom);
      serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
      if (kind == 2)
        serve($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom);
    end

    @(negedge clk);
    chk("final_idle", {inst_data_ok, data_data_ok, arvalid, awvalid, wvalid}, 5'b0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/sram_axi_bridge.md
# sram_axi_bridge

- Sits directly downstream of the CPU core's instruction and data SRAM-like ports.
- Converts the two request/acknowledge channels into a single AXI3 master for the SoC interconnect.
- Arbitrates between the instruction and data sides and holds one transaction outstanding at a time.
- Generates the AXI size and write-strobe fields from the request size and address.

## Interface
Parameters:
- ID_W, 4, AXI ID width
- INST_ID, 0, ARID used for instruction reads
- DATA_ID, 1, ARID/AWID used for data accesses

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  reset, synchronous, active-low
- inst_req / data_req  in  1  request valid
- inst_wr / data_wr  in  1  1 = write, 0 = read
- inst_size / data_size  in  2  0 = byte, 1 = half, 2 = word
- inst_addr / data_addr  in  32  byte address
- inst_wdata / data_wdata  in  32  write data, byte lanes aligned to addr[1:0]
- inst_addr_ok / data_addr_ok  out  1  request accepted this cycle
- inst_data_ok / data_data_ok  out  1  read data valid, or write completed, this cycle
- inst_rdata / data_rdata  out  32  read data, valid while data_ok = 1
- arid, araddr, arsize, arvalid  out  ID_W/32/3/1  AXI read address channel
- arready  in  1  AXI read address ready
- rid, rdata, rresp, rlast, rvalid  in  ID_W/32/2/1/1  AXI read data channel
- rready  out  1  AXI read data ready
- awid, awaddr, awsize, awvalid  out  ID_W/32/3/1  AXI write address channel
- awready  in  1  AXI write address ready
- wid, wdata, wstrb, wlast, wvalid  out  ID_W/32/4/1/1  AXI write data channel
- wready  in  1  AXI write data ready
- bid, bresp, bvalid  in  ID_W/2/1  AXI write response channel
- bready  out  1  AXI write response ready

Tied-off AXI fields, held constant:
- arlen/awlen = 0
- arburst/awburst = 2'b01
- arlock/awlock = 0
- arcache/awcache = 0
- arprot/awprot = 0
- wlast = 1
- wid = awid

## Operation
State machine:
- IDLE, RD_AR, RD_R, WR_AW_W, WR_B.

IDLE:
- When data_req = 1, data_addr_ok = 1 combinationally.
- When inst_req = 1 and data_req = 0, inst_addr_ok = 1 combinationally.
- If both request in the same cycle, data wins. inst_addr_ok stays 0, and inst_req is held until accepted.
- On acceptance, latch owner (inst/data), wr, size, addr and wdata.
- Next state: RD_AR if wr = 0, WR_AW_W if wr = 1.

RD_AR:
- arvalid = 1, araddr = latched addr, arsize = {1'b0, size}, arid = owner ID.
- On arvalid & arready, go to RD_R.

RD_R:
- rready = 1.
- On rvalid: pulse the owner's data_ok for that cycle, pass rdata straight through, return to IDLE.

WR_AW_W:
- awvalid = 1 and wvalid = 1 together.
- Each channel drops its valid after its own handshake; aw_done and w_done flags track this.
- Go to WR_B when both are done, including both completing in the same cycle.

WR_B:
- bready = 1.
- On bvalid, pulse the owner's data_ok and return to IDLE.

Write strobe:
- size 0: wstrb = 4'b0001 << addr[1:0]
- size 1: wstrb = 4'b0011 << addr[1:0]
- size 2: wstrb = 4'b1111
- Any other size: treated as word.
- wdata is passed unmodified.

Other rules:
- addr_ok is never asserted outside IDLE. The only exception is the IDLE entry cycle itself: in the cycle data_ok pulses, the state is still RD_R/WR_B, so the new addr_ok appears at the earliest one cycle later.
- An instruction-side write (inst_wr = 1) is handled as a write, with no special case.
- rresp and bresp are ignored; no error reporting.
- Outstanding transactions: at most 1.

## Timing
Reset:
- While resetn = 0 at a rising edge, next state = IDLE and the aw_done/w_done flags are cleared.
- All valid/ready outputs and all addr_ok/data_ok are 0 during reset.
- Latched registers clear to 0, so araddr/awaddr/wdata read 0.

Reset mid-transaction:
- Abort immediately and drop valids without completing the handshake. The interconnect is reset in the same domain.

Best-case latencies:
- Read: accept cycle T; ARVALID at T+1; data_ok at T+2 if arready and rvalid are each immediate.
- Write: accept cycle T; AW/W at T+1; data_ok at T+2.

Back-to-back:
- After a data_ok at cycle T, the next addr_ok can occur at T+1.

Handshake stability:
- AXI valids remain asserted and payloads remain stable until ready is sampled high (AXI rule).
- SRAM side: req/addr/wdata are sampled only in the addr_ok cycle.

## Test plan
- Instruction read: inst_req=1, addr 0xBFC00000, size 2; arready=1, rvalid at +2 with rdata 0x3C011234 -> araddr 0xBFC00000, arid 0, arsize 2; inst_data_ok for exactly one cycle with inst_rdata 0x3C011234.
- Byte store: data_wr=1, size 0, addr 0x00001003, wdata 0xAA000000 -> wstrb 4'b1000, awsize 0, awid 1; data_data_ok only after bvalid.
- Simultaneous inst and data reads -> data served first (arid 1); inst_addr_ok asserted in the first IDLE cycle after data_data_ok; then arid 0.
- Split write handshake: awready high at +1, wready held low for 3 cycles -> awvalid drops after +1, wvalid stays high until wready, then bready; no duplicate AW.
- Backpressure: arready low for 5 cycles -> arvalid and araddr stable all 5 cycles; no addr_ok to either side during that time.
- Reset mid-read: resetn=0 while in RD_R -> next cycle all valids/ready = 0, state IDLE; after resetn=1 a new request is accepted normally.
